// File: rtl/axi4lite_slave_regif.sv
// AXI4-Lite responder bridging AW/W/B/AR/R onto a single-cycle register bus.
// One write and one read outstanding at most; register-bus accesses are serialized.
module axi4lite_slave_regif #(
  parameter int bus_width  = 32,
  parameter int addr_width = 5
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic [addr_width-1:0]   awaddr,
  input  logic                    awvalid,
  output logic                    awready,
  input  logic [2:0]              awprot,
  input  logic [bus_width-1:0]    wdata,
  input  logic [bus_width/8-1:0]  wstrb,
  input  logic                    wvalid,
  output logic                    wready,
  output logic [1:0]              bresp,
  output logic                    bvalid,
  input  logic                    bready,
  input  logic [addr_width-1:0]   araddr,
  input  logic                    arvalid,
  output logic                    arready,
  input  logic [2:0]              arprot,
  output logic [bus_width-1:0]    rdata,
  output logic [1:0]              rresp,
  output logic                    rvalid,
  input  logic                    rready,
  output logic [addr_width-1:0]   reg_addr,
  output logic                    reg_wr_en,
  output logic [bus_width-1:0]    reg_wr_data,
  output logic [bus_width/8-1:0]  reg_wr_strb,
  input  logic                    reg_wr_err,
  output logic                    reg_rd_en,
  input  logic [bus_width-1:0]    reg_rd_data,
  input  logic                    reg_rd_err
);
  localparam int STRB_W = bus_width / 8;
  localparam int WA_W   = addr_width - 2;

  typedef enum logic [2:0] {IDLE, WR_ACCESS, WR_RESP, RD_ACCESS, RD_RESP} state_t;

  state_t              r_state, w_next;
  logic                r_aw_full, r_w_full, r_ar_full;
  logic [WA_W-1:0]     r_aw_addr, r_ar_addr;
  logic [bus_width-1:0] r_w_data, r_rdata;
  logic [STRB_W-1:0]   r_w_strb;
  logic                r_wr_err, r_rd_err;
  logic                r_last_rd;
  logic                w_aw_hs, w_w_hs, w_ar_hs, w_b_hs, w_r_hs;
  logic                w_wr_pend, w_rd_pend, w_contend;
  logic                w_unused;

  assign w_unused  = ^{awprot, arprot};

  assign awready   = !r_aw_full;
  assign wready    = !r_w_full;
  assign arready   = !r_ar_full;

  assign w_aw_hs   = awvalid && !r_aw_full;
  assign w_w_hs    = wvalid  && !r_w_full;
  assign w_ar_hs   = arvalid && !r_ar_full;
  assign w_b_hs    = (r_state == WR_RESP) && bready;
  assign w_r_hs    = (r_state == RD_RESP) && rready;

  assign w_wr_pend = r_aw_full && r_w_full;
  assign w_rd_pend = r_ar_full;

  assign reg_wr_data = r_w_data;
  assign reg_wr_strb = r_w_strb;
  assign rdata       = r_rdata;

  // Write-side holds: released only once the B handshake completes
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_aw_full <= 1'b0;
      r_aw_addr <= '0;
      r_w_full  <= 1'b0;
      r_w_data  <= '0;
      r_w_strb  <= '0;
    end else begin
      if (w_b_hs) begin
        r_aw_full <= 1'b0;
        r_w_full  <= 1'b0;
      end else begin
        if (w_aw_hs) begin
          r_aw_full <= 1'b1;
          r_aw_addr <= awaddr[addr_width-1:2];
        end
        if (w_w_hs) begin
          r_w_full <= 1'b1;
          r_w_data <= wdata;
          r_w_strb <= wstrb;
        end
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_ar_full <= 1'b0;
      r_ar_addr <= '0;
    end else if (w_r_hs) begin
      r_ar_full <= 1'b0;
    end else if (w_ar_hs) begin
      r_ar_full <= 1'b1;
      r_ar_addr <= araddr[addr_width-1:2];
    end
  end

  // Access results, captured during the one-cycle register-bus strobe
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_wr_err <= 1'b0;
      r_rd_err <= 1'b0;
      r_rdata  <= '0;
    end else begin
      if (r_state == WR_ACCESS) r_wr_err <= reg_wr_err;
      if (r_state == RD_ACCESS) begin
        r_rdata  <= reg_rd_data;
        r_rd_err <= reg_rd_err;
      end
    end
  end

  // Round-robin memory only moves on contested grants, so a repeated
  // simultaneous write+read alternates which side goes first.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_last_rd <= 1'b1;
    end else if (w_contend) begin
      r_last_rd <= (w_next == RD_ACCESS);
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) r_state <= IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    w_contend = 1'b0;
    reg_wr_en = 1'b0;
    reg_rd_en = 1'b0;
    reg_addr  = '0;
    bvalid    = 1'b0;
    bresp     = 2'b00;
    rvalid    = 1'b0;
    rresp     = 2'b00;
    case (r_state)
      IDLE: begin
        if (w_wr_pend && w_rd_pend) begin
          w_contend = 1'b1;
          w_next    = r_last_rd ? WR_ACCESS : RD_ACCESS;
        end else if (w_wr_pend) begin
          w_next = WR_ACCESS;
        end else if (w_rd_pend) begin
          w_next = RD_ACCESS;
        end
      end
      WR_ACCESS: begin
        reg_wr_en = 1'b1;
        reg_addr  = {r_aw_addr, 2'b00};
        w_next    = WR_RESP;
      end
      WR_RESP: begin
        bvalid = 1'b1;
        bresp  = r_wr_err ? 2'b10 : 2'b00;
        if (bready) w_next = IDLE;
      end
      RD_ACCESS: begin
        reg_rd_en = 1'b1;
        reg_addr  = {r_ar_addr, 2'b00};
        w_next    = RD_RESP;
      end
      RD_RESP: begin
        rvalid = 1'b1;
        rresp  = r_rd_err ? 2'b10 : 2'b00;
        if (rready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_axi4lite_slave_regif.sv
// Scoreboard bench for axi4lite_slave_regif: expected register accesses and
// B/R responses are queued at stimulus time and popped by a negedge monitor.
module tb_axi4lite_slave_regif;
  localparam int BW = 32;
  localparam int AW = 5;
  localparam int SW = BW / 8;

  logic          aclk = 1'b0;
  logic          aresetn;
  logic [AW-1:0] awaddr, araddr, reg_addr;
  logic          awvalid, awready, wvalid, wready, bvalid, bready;
  logic          arvalid, arready, rvalid, rready;
  logic [2:0]    awprot, arprot;
  logic [BW-1:0] wdata, rdata, reg_wr_data, reg_rd_data;
  logic [SW-1:0] wstrb, reg_wr_strb;
  logic [1:0]    bresp, rresp;
  logic          reg_wr_en, reg_rd_en, reg_wr_err, reg_rd_err;

  logic [BW-1:0] rd_data_drv;
  logic          rd_err_drv, wr_err_drv;
  assign reg_rd_data = rd_data_drv;
  assign reg_rd_err  = rd_err_drv;
  assign reg_wr_err  = wr_err_drv;

  always #5 aclk = ~aclk;

  axi4lite_slave_regif #(.bus_width(BW), .addr_width(AW)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready), .awprot(awprot),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arvalid(arvalid), .arready(arready), .arprot(arprot),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .reg_addr(reg_addr), .reg_wr_en(reg_wr_en), .reg_wr_data(reg_wr_data),
    .reg_wr_strb(reg_wr_strb), .reg_wr_err(reg_wr_err), .reg_rd_en(reg_rd_en),
    .reg_rd_data(reg_rd_data), .reg_rd_err(reg_rd_err)
  );

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [BW-1:0] data;
    logic [SW-1:0] strb;
  } wr_exp_t;

  wr_exp_t       q_wr[$];
  logic [AW-1:0] q_rd[$];
  logic [1:0]    q_b[$];
  logic [BW+1:0] q_r[$];   // {rresp, rdata}

  int n_cmp = 0;
  int n_err = 0;
  int acc_seq = 0, wr_seq = 0, rd_seq = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  // Monitor: compares every register-bus strobe and every B/R handshake
  initial begin
    wr_exp_t       e;
    logic [BW+1:0] r;
    forever begin
      @(negedge aclk);
      if (reg_wr_en || reg_rd_en) chk("en_excl", {reg_wr_en, reg_rd_en} == 2'b11, 0);
      if (reg_wr_en) begin
        acc_seq++; wr_seq = acc_seq;
        chk("wr_expected", q_wr.size() > 0, 1);
        if (q_wr.size() > 0) begin
          e = q_wr.pop_front();
          chk("wr_addr", reg_addr, e.addr);
          chk("wr_data", reg_wr_data, e.data);
          chk("wr_strb", reg_wr_strb, e.strb);
        end
      end
      if (reg_rd_en) begin
        acc_seq++; rd_seq = acc_seq;
        chk("rd_expected", q_rd.size() > 0, 1);
        if (q_rd.size() > 0) chk("rd_addr", reg_addr, q_rd.pop_front());
      end
      if (bvalid && bready) begin
        chk("b_expected", q_b.size() > 0, 1);
        if (q_b.size() > 0) chk("bresp", bresp, q_b.pop_front());
      end
      if (rvalid && rready) begin
        chk("r_expected", q_r.size() > 0, 1);
        if (q_r.size() > 0) begin
          r = q_r.pop_front();
          chk("rdata", rdata, r[BW-1:0]);
          chk("rresp", rresp, r[BW+1:BW]);
        end
      end
    end
  end

  // Drive any mix of AW/W/AR from just after a posedge; returns just after the
  // edge where the last requested channel handshook.
  task automatic xfer(input bit do_aw, input bit do_w, input bit do_ar,
                      input logic [AW-1:0] aa, input logic [BW-1:0] wd,
                      input logic [SW-1:0] ws, input logic [AW-1:0] ra);
    logic ha, hw, hr;
    awvalid = do_aw; awaddr = aa; awprot = 3'($urandom_range(0, 7));
    wvalid  = do_w;  wdata  = wd; wstrb  = ws;
    arvalid = do_ar; araddr = ra; arprot = 3'($urandom_range(0, 7));
    for (int k = 0; k < 40 && (awvalid || wvalid || arvalid); k++) begin
      @(negedge aclk);
      ha = awvalid && awready;
      hw = wvalid && wready;
      hr = arvalid && arready;
      @(posedge aclk); #1;
      if (ha) awvalid = 1'b0;
      if (hw) wvalid  = 1'b0;
      if (hr) arvalid = 1'b0;
    end
    chk("xfer_done", {awvalid, wvalid, arvalid}, 0);
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
  endtask

  // Called just after handshake edge E0; k counts edges since E0 at the negedge
  // where the response valid is first seen, en_k where the strobe was seen.
  task automatic wait_valid(input bit is_r, output int k, output int en_k);
    en_k = -1;
    for (k = 0; k < 50; k++) begin
      @(negedge aclk);
      if (is_r ? reg_rd_en : reg_wr_en) en_k = k;
      if (is_r ? rvalid : bvalid) break;
    end
  endtask

  task automatic drain(input string tag);
    int k;
    for (k = 0; k < 60; k++) begin
      @(negedge aclk);
      if (q_wr.size() == 0 && q_rd.size() == 0 && q_b.size() == 0 && q_r.size() == 0) break;
    end
    chk(tag, k < 60, 1);
    @(posedge aclk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, en_k;
    aresetn = 1'b0;
    awvalid = 0; wvalid = 0; arvalid = 0; bready = 1; rready = 1;
    awaddr = 0; araddr = 0; wdata = 0; wstrb = 0; awprot = 0; arprot = 0;
    rd_data_drv = 0; rd_err_drv = 0; wr_err_drv = 0;

    // Reset state
    #12;
    chk("rst_ready", {awready, wready, arready}, 3'b111);
    chk("rst_valid", {bvalid, rvalid, reg_wr_en, reg_rd_en}, 4'b0000);
    chk("rst_resp", {bresp, rresp}, 4'b0000);
    chk("rst_rdata", rdata, 0);
    chk("rst_regbus", {reg_addr, reg_wr_data, reg_wr_strb}, 0);
    @(negedge aclk); aresetn = 1'b1;
    @(posedge aclk); #1;

    // T1: AW+W same cycle
    q_wr.push_back('{5'h08, 32'hDEADBEEF, 4'hF}); q_b.push_back(2'b00);
    xfer(1, 1, 0, 5'h08, 32'hDEADBEEF, 4'hF, 5'h00);
    wait_valid(0, k, en_k);
    chk("t1_en_lat", en_k, 1);
    chk("t1_b_lat", k, 2);
    @(posedge aclk); #1;

    // T2: W two cycles ahead of AW, then a read of the same register
    q_wr.push_back('{5'h0C, 32'hCAFE0001, 4'h3}); q_b.push_back(2'b00);
    xfer(0, 1, 0, 5'h00, 32'hCAFE0001, 4'h3, 5'h00);
    @(negedge aclk);
    chk("t2_w_held", {awready, wready, reg_wr_en}, 3'b100);
    @(posedge aclk); #1;
    xfer(1, 0, 0, 5'h0C, 32'h0, 4'h0, 5'h00);
    wait_valid(0, k, en_k);
    chk("t2_b_lat", k, 2);
    @(posedge aclk); #1;
    rd_data_drv = 32'h12345678;
    q_rd.push_back(5'h0C); q_r.push_back({2'b00, 32'h12345678});
    xfer(0, 0, 1, 5'h00, 32'h0, 4'h0, 5'h0C);
    wait_valid(1, k, en_k);
    chk("t2_rd_en_lat", en_k, 1);
    chk("t2_r_lat", k, 2);
    @(posedge aclk); #1;

    // T3: AW/W/AR together after reset -> write first; repeat -> read first
    #2 aresetn = 1'b0;
    @(negedge aclk); aresetn = 1'b1;
    @(posedge aclk); #1;
    rd_data_drv = 32'h22222222;
    q_wr.push_back('{5'h10, 32'h11111111, 4'hF}); q_b.push_back(2'b00);
    q_rd.push_back(5'h14); q_r.push_back({2'b00, 32'h22222222});
    xfer(1, 1, 1, 5'h10, 32'h11111111, 4'hF, 5'h14);
    drain("t3a_drain");
    chk("t3a_wr_first", wr_seq < rd_seq, 1);
    rd_data_drv = 32'h44444444;
    q_wr.push_back('{5'h18, 32'h33333333, 4'hF}); q_b.push_back(2'b00);
    q_rd.push_back(5'h04); q_r.push_back({2'b00, 32'h44444444});
    xfer(1, 1, 1, 5'h18, 32'h33333333, 4'hF, 5'h04);
    drain("t3b_drain");
    chk("t3b_rd_first", rd_seq < wr_seq, 1);

    // T4: error responses, unaligned write address, zero strobe
    wr_err_drv = 1'b1;
    q_wr.push_back('{5'h10, 32'h0BADF00D, 4'hF}); q_b.push_back(2'b10);
    xfer(1, 1, 0, 5'h13, 32'h0BADF00D, 4'hF, 5'h00);
    drain("t4w_drain");
    wr_err_drv = 1'b0;
    rd_err_drv = 1'b1; rd_data_drv = 32'h5555AAAA;
    q_rd.push_back(5'h1C); q_r.push_back({2'b10, 32'h5555AAAA});
    xfer(0, 0, 1, 5'h00, 32'h0, 4'h0, 5'h1C);
    drain("t4r_drain");
    rd_err_drv = 1'b0;
    q_wr.push_back('{5'h04, 32'h00000077, 4'h0}); q_b.push_back(2'b00);
    xfer(1, 1, 0, 5'h04, 32'h00000077, 4'h0, 5'h00);
    drain("t4s_drain");

    // T5: bready low 5 cycles, AR accepted during WR_RESP
    bready = 1'b0; rd_data_drv = 32'hA5A50004;
    q_wr.push_back('{5'h08, 32'h00000099, 4'hF}); q_b.push_back(2'b00);
    q_rd.push_back(5'h04); q_r.push_back({2'b00, 32'hA5A50004});
    xfer(1, 1, 0, 5'h08, 32'h00000099, 4'hF, 5'h00);
    wait_valid(0, k, en_k);
    chk("t5_b_lat", k, 2);
    for (int i = 0; i < 5; i++) begin
      @(posedge aclk); #1;
      if (i == 0) begin arvalid = 1'b1; araddr = 5'h04; end
      if (i == 1) arvalid = 1'b0;
      @(negedge aclk);
      chk("t5_b_hold", {bvalid, bresp, awready, wready}, 5'b10000);
      if (i == 0) chk("t5_arready", arready, 1);
      if (i == 2) chk("t5_ar_held", arready, 0);
    end
    @(posedge aclk); #1; bready = 1'b1;
    @(posedge aclk); #1;
    @(negedge aclk);
    chk("t5_aw_back", {awready, wready, bvalid}, 3'b110);
    drain("t5_drain");

    // T6: reset during RD_RESP drops the response
    rready = 1'b0; rd_data_drv = 32'hFEEDFACE;
    q_rd.push_back(5'h08);
    xfer(0, 0, 1, 5'h00, 32'h0, 4'h0, 5'h08);
    wait_valid(1, k, en_k);
    chk("t6_r_lat", k, 2);
    #2 aresetn = 1'b0;
    #1;
    chk("t6_async_clr", {rvalid, arready, rresp}, 4'b0100);
    chk("t6_rdata_clr", rdata, 0);
    rready = 1'b1;
    @(posedge aclk); #3 aresetn = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge aclk);
      chk("t6_idle", {rvalid, bvalid, arready, reg_rd_en, reg_wr_en}, 5'b00100);
    end

    chk("q_empty", q_wr.size() + q_rd.size() + q_b.size() + q_r.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
